// File: rtl/adc_ltc2308_seq.sv
// rtl/adc_ltc2308_seq.sv - LTC2308 SPI ADC round-robin channel sequencer
//
// Purpose: scans a runtime channel mask round-robin, runs one CONVST/SPI
// frame per conversion and presents each result tagged with its channel as
// a one-clock RESULT_VALID pulse. The LTC2308 returns the result of the
// previous frame's config word, so the first frame after a start is only
// used to prime the converter.
//
// Optional build macro: ADC_AVG4_EN - each channel is converted on 4
// consecutive frames and one pulse carries the 4-sample average.
//
// Ports:
//   CLK          in   system clock (50 MHz)
//   RESET_N      in   asynchronous active-low reset
//   EN           in   1 = scan continuously, 0 = stop after current frame
//   CH_MASK      in   [7:0] channels to scan, bit n = channel n
//   ADC_CONVST   out  conversion start
//   ADC_SCK      out  SPI clock, idles low
//   ADC_SDI      out  6-bit config word, MSB first
//   ADC_SDO      in   serial result from ADC
//   RESULT_VALID out  one-clock result pulse
//   RESULT_CH    out  [2:0] channel of RESULT_DATA
//   RESULT_DATA  out  [11:0] conversion result
//   BUSY         out  high whenever the sequencer is not idle

module adc_ltc2308_seq #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int ACQ_CYCLES  = 20
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        EN,
    input  logic [7:0]  CH_MASK,
    output logic        ADC_CONVST,
    output logic        ADC_SCK,
    output logic        ADC_SDI,
    input  logic        ADC_SDO,
    output logic        RESULT_VALID,
    output logic [2:0]  RESULT_CH,
    output logic [11:0] RESULT_DATA,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2,
        S_ACQ   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic        convst_q, convst_d;
    logic [5:0]  cfg_sr_q, cfg_sr_d;
    logic [11:0] sh_q, sh_d;
    logic [2:0]  ch_q, ch_d;
    logic [2:0]  prev_ch_q, prev_ch_d;
    logic        prime_q, prime_d;
    logic        valid_q, valid_d;
    logic [2:0]  res_ch_q, res_ch_d;
    logic [11:0] res_data_q, res_data_d;
    logic        busy_q, busy_d;
`ifdef ADC_AVG4_EN
    logic [13:0] acc_q, acc_d;
    logic [13:0] sum;
    logic [1:0]  rcnt_q, rcnt_d;
    logic [1:0]  rep_q, rep_d;
`endif

    // Next set bit of mask strictly after cur, wrapping 7->0. Offset 8
    // wraps back onto cur itself, so a lone set bit repeats. Called with
    // cur = 7 it yields the lowest set bit.
    function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] res;
        logic [2:0] c;
        res = cur;
        for (int i = 8; i >= 1; i--) begin
            c = cur + 3'(i);
            if (mask[c]) res = c;
        end
        return res;
    endfunction

    // {single-ended, odd/sign = ch[0], sel1 = ch[2], sel0 = ch[1], unipolar, no sleep}
    function automatic logic [5:0] cfg_word(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        convst_d   = convst_q;
        cfg_sr_d   = cfg_sr_q;
        sh_d       = sh_q;
        ch_d       = ch_q;
        prev_ch_d  = prev_ch_q;
        prime_d    = prime_q;
        valid_d    = 1'b0;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
`ifdef ADC_AVG4_EN
        acc_d      = acc_q;
        rcnt_d     = rcnt_q;
        rep_d      = rep_q;
        sum        = acc_q + {2'b00, sh_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (EN && (CH_MASK != 8'h00)) begin
                    ch_d     = next_ch(CH_MASK, 3'd7);
                    prime_d  = 1'b0;
                    convst_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_CONV;
`ifdef ADC_AVG4_EN
                    acc_d    = '0;
                    rcnt_d   = '0;
                    rep_d    = '0;
`endif
                end
            end

            S_CONV: begin
                if (cnt_q == 16'(CONV_CYCLES - 1)) begin
                    convst_d = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    sck_d    = 1'b0;
                    // SDI shows config bit 5 from the first SHIFT clock.
                    cfg_sr_d = cfg_word(ch_q);
                    state_d  = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_SHIFT: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Rising SCK: capture SDO, first sample ends up in bit 11.
                        sck_d = 1'b1;
                        sh_d  = {sh_q[10:0], ADC_SDO};
                    end else begin
                        sck_d = 1'b0;
                        // Zero fill makes SDI 0 for bits 6..11 and after the frame.
                        cfg_sr_d = {cfg_sr_q[4:0], 1'b0};
                        if (bit_q == 4'd11) begin
                            state_d = S_ACQ;
                            prime_d = 1'b1;
                            if (prime_q) begin
`ifdef ADC_AVG4_EN
                                if (rcnt_q == 2'd3) begin
                                    valid_d    = 1'b1;
                                    res_ch_d   = prev_ch_q;
                                    res_data_d = sum[13:2];
                                    acc_d      = '0;
                                    rcnt_d     = '0;
                                end else begin
                                    acc_d  = sum;
                                    rcnt_d = rcnt_q + 2'd1;
                                end
`else
                                valid_d    = 1'b1;
                                res_ch_d   = prev_ch_q;
                                res_data_d = sh_q;
`endif
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_ACQ: begin
                if (cnt_q == 16'(ACQ_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (!EN || (CH_MASK == 8'h00)) begin
                        state_d = S_IDLE;
                    end else begin
                        prev_ch_d = ch_q;
`ifdef ADC_AVG4_EN
                        if (rep_q == 2'd3) begin
                            rep_d = '0;
                            ch_d  = next_ch(CH_MASK, ch_q);
                        end else begin
                            rep_d = rep_q + 2'd1;
                        end
`else
                        ch_d = next_ch(CH_MASK, ch_q);
`endif
                        convst_d = 1'b1;
                        state_d  = S_CONV;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sck_q      <= 1'b0;
            convst_q   <= 1'b0;
            cfg_sr_q   <= '0;
            sh_q       <= '0;
            ch_q       <= '0;
            prev_ch_q  <= '0;
            prime_q    <= 1'b0;
            valid_q    <= 1'b0;
            res_ch_q   <= '0;
            res_data_q <= '0;
            busy_q     <= 1'b0;
`ifdef ADC_AVG4_EN
            acc_q      <= '0;
            rcnt_q     <= '0;
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            convst_q   <= convst_d;
            cfg_sr_q   <= cfg_sr_d;
            sh_q       <= sh_d;
            ch_q       <= ch_d;
            prev_ch_q  <= prev_ch_d;
            prime_q    <= prime_d;
            valid_q    <= valid_d;
            res_ch_q   <= res_ch_d;
            res_data_q <= res_data_d;
            busy_q     <= busy_d;
`ifdef ADC_AVG4_EN
            acc_q      <= acc_d;
            rcnt_q     <= rcnt_d;
            rep_q      <= rep_d;
`endif
        end
    end

    assign ADC_CONVST   = convst_q;
    assign ADC_SCK      = sck_q;
    assign ADC_SDI      = cfg_sr_q[5];
    assign RESULT_VALID = valid_q;
    assign RESULT_CH    = res_ch_q;
    assign RESULT_DATA  = res_data_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_adc_ltc2308_seq.sv
// tb/tb_adc_ltc2308_seq.sv - scoreboard bench for adc_ltc2308_seq with LTC2308 model

module tb_adc_ltc2308_seq;

    localparam int CLK_DIV = 2;
    localparam int CONV    = 80;
    localparam int ACQ     = 20;
    localparam int FRAME   = CONV + 24 * CLK_DIV + ACQ;
`ifdef ADC_AVG4_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        EN;
    logic [7:0]  CH_MASK;
    logic        ADC_CONVST, ADC_SCK, ADC_SDI;
    logic        adc_sdo = 1'b0;
    logic        RESULT_VALID;
    logic [2:0]  RESULT_CH;
    logic [11:0] RESULT_DATA;
    logic        BUSY;

    adc_ltc2308_seq #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV), .ACQ_CYCLES(ACQ)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .CH_MASK(CH_MASK),
        .ADC_CONVST(ADC_CONVST), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI), .ADC_SDO(adc_sdo),
        .RESULT_VALID(RESULT_VALID), .RESULT_CH(RESULT_CH), .RESULT_DATA(RESULT_DATA), .BUSY(BUSY)
    );

    always #10 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests  = 0;
    int   failed = 0;
    int   run_id = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] c);
        int k;
        for (int i = 1; i <= 8; i++) begin
            k = (int'(c) + i) % 8;
            if (m[k]) return 3'(k);
        end
        return c;
    endfunction

    function automatic logic [5:0] cfg_of(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    endfunction

    // LTC2308 model and reference: expected channel order from the mask,
    // random conversion values, results tagged with the previous frame's channel.
    int          m_run = 0, m_k = 0, m_rep = 0, acc_sum = 0, acc_n = 0;
    int          cyc = 0, conv_w = 0, hi_w = 0, sck_cnt = 0, sdo_idx = -1;
    logic [2:0]  m_ch = 3'd0, tag;
    logic [11:0] word = 12'd0;
    logic [5:0]  cfg_cap = 6'd0;
    logic        prev_cv = 1'b0, prev_sck = 1'b0, first;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_cv  = 1'b0;
            prev_sck = 1'b0;
            conv_w   = 0;
            hi_w     = 0;
            sdo_idx  = -1;
            adc_sdo  = 1'b0;
        end else begin
            cyc++;
            if (ADC_CONVST && !prev_cv) begin
                first = (run_id != m_run);
                tag   = m_ch;
                if (first) begin
                    m_run   = run_id;
                    m_k     = 0;
                    m_rep   = 0;
                    acc_sum = 0;
                    acc_n   = 0;
                    m_ch    = next_set(CH_MASK, 3'd7);
                end else begin
                    check("frame_period", cyc, FRAME);
                    check("sck_pulses", sck_cnt, 12);
                    if (AVG && m_rep < 3) m_rep++;
                    else begin
                        m_rep = 0;
                        m_ch  = next_set(CH_MASK, m_ch);
                    end
                    m_k++;
                end
                word = 12'($urandom);
                if (!first) begin
                    if (AVG) begin
                        acc_sum += int'(word);
                        acc_n++;
                        if (acc_n == 4) begin
                            sb_q.push_back('{ch: tag, data: 12'(acc_sum / 4)});
                            acc_sum = 0;
                            acc_n   = 0;
                        end
                    end else begin
                        sb_q.push_back('{ch: tag, data: word});
                    end
                end
                cyc     = 0;
                sck_cnt = 0;
                cfg_cap = 6'd0;
            end
            if (ADC_CONVST) conv_w++;
            if (!ADC_CONVST && prev_cv) begin
                check("convst_width", conv_w, CONV);
                conv_w  = 0;
                adc_sdo = word[11];
                sdo_idx = 10;
            end
            if (ADC_SCK) hi_w++;
            if (ADC_SCK && !prev_sck) begin
                sck_cnt++;
                if (sck_cnt <= 6) cfg_cap = {cfg_cap[4:0], ADC_SDI};
                if (sck_cnt == 6) check("sdi_config", cfg_cap, cfg_of(m_ch));
            end
            if (!ADC_SCK && prev_sck) begin
                check("sck_high_width", hi_w, CLK_DIV);
                hi_w = 0;
                if (sdo_idx >= 0) begin
                    adc_sdo = word[sdo_idx];
                    sdo_idx--;
                end
            end
            prev_cv  = ADC_CONVST;
            prev_sck = ADC_SCK;
        end
    end

    // Monitor: every result pulse pops and checks one expected entry.
    always @(negedge CLK) begin
        if (RESULT_VALID) begin
            if (sb_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_result: got pulse ch %0d data 0x%0h, required no pulse",
                         RESULT_CH, RESULT_DATA);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_ch", RESULT_CH, mon_e.ch);
                check("result_data", RESULT_DATA, mon_e.data);
            end
        end
    end

    task automatic wait_convst_rises(input int n);
        int   seen = 0;
        int   budget = 0;
        logic p = ADC_CONVST;
        while (seen < n && budget < (n + 2) * FRAME) begin
            @(negedge CLK);
            budget++;
            if (ADC_CONVST && !p) seen++;
            p = ADC_CONVST;
        end
        check("convst_wait", seen, n);
    endtask

    task automatic wait_sck_rises(input int n);
        int   seen = 0;
        int   budget = 0;
        logic p = ADC_SCK;
        while (seen < n && budget < 2 * FRAME) begin
            @(negedge CLK);
            budget++;
            if (ADC_SCK && !p) seen++;
            p = ADC_SCK;
        end
        check("sck_wait", seen, n);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (BUSY && budget < 2 * FRAME) begin
            @(negedge CLK);
            budget++;
        end
        check("idle_wait", int'(BUSY), 0);
    endtask

    logic [7:0] masks[6];
    int         found;
    int         nf;

    initial begin
        RESET_N = 1'b0;
        EN      = 1'b1;
        CH_MASK = 8'h05;
        masks[0] = 8'h05;
        masks[1] = 8'h80;
        for (int i = 2; i < 6; i++) begin
            masks[i] = 8'($urandom_range(1, 255));
        end

        repeat (5) @(negedge CLK);
        check("reset_outputs",
              int'({ADC_CONVST, ADC_SCK, ADC_SDI, RESULT_VALID, RESULT_CH, RESULT_DATA, BUSY}), 0);

        run_id  = 1;
        RESET_N = 1'b1;
        found   = 0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge CLK);
            if (ADC_CONVST && found == 0) found = i;
        end
        check("convst_after_reset", int'(found != 0), 1);
        check("busy_running", int'(BUSY), 1);

        for (int r = 0; r < 6; r++) begin
            if (r > 0) begin
                CH_MASK = masks[r];
                run_id++;
                EN = 1'b1;
            end
            nf = int'($urandom_range(2, 5)) + (AVG ? 8 : 0);
            wait_convst_rises(nf);
            wait_sck_rises(4);
            EN = 1'b0;
            wait_idle();
            repeat (3) @(negedge CLK);
            check("idle_busy", int'(BUSY), 0);
            check("idle_convst", int'(ADC_CONVST), 0);
            check("scoreboard_drained", sb_q.size(), 0);
        end

        CH_MASK = 8'($urandom_range(1, 255));
        run_id++;
        EN = 1'b1;
        wait_convst_rises(2);
        wait_sck_rises(3);
        RESET_N = 1'b0;
        EN      = 1'b0;
        @(negedge CLK);
        check("midframe_reset_outputs",
              int'({ADC_CONVST, ADC_SCK, ADC_SDI, RESULT_VALID, RESULT_CH, RESULT_DATA, BUSY}), 0);
        sb_q.delete();
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("post_reset_idle", int'({BUSY, ADC_CONVST}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
